// File: rtl/c2_bus_master.sv
// c2_bus_master: cache-side C2 bus initiator moving one whole line per read or write request.
// Define C2_TIMEOUT_EN to bound the wait for C2_RESPONSE and report a timeout through resp_err.
module c2_bus_master #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int LINE_BYTES = 16,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [LINE_BYTES*8-1:0] req_wdata,
  output logic                    resp_valid,
  output logic [LINE_BYTES*8-1:0] resp_rdata,
  output logic                    resp_err,
  output logic [ADDR_W-1:0]       addr,
  inout  wire  [DATA_W-1:0]       data_w,
  inout  wire  [1:0]              cmd_w
);
  localparam int BEATS = LINE_BYTES*8/DATA_W;
  localparam int BW = $clog2(BEATS+1);
  localparam logic [BW-1:0] LAST = BW'(BEATS-1);
  localparam logic [1:0] C2_NOP = 2'd0, C2_READ_LINE = 2'd1, C2_WRITE_LINE = 2'd2, C2_RESPONSE = 2'd3;
  typedef enum logic [2:0] {IDLE, RD_CMD, RD_WAIT, RD_BEAT, WR_BEAT, WR_WAIT, DONE} state_t;
  state_t state, state_n;
  logic own, got_resp, timeout, store, waiting;
  logic [BW-1:0] beat;
  logic [LINE_BYTES*8-1:0] line, rbuf, rbuf_n;
  logic [1:0] smp_cmd;
  logic [DATA_W-1:0] smp_data;
  assign got_resp = smp_cmd == C2_RESPONSE;
  assign waiting = state == RD_WAIT || state == WR_WAIT;
  assign store = (state == RD_WAIT && got_resp) || state == RD_BEAT;
  assign req_ready = state == IDLE;
  assign resp_valid = state == DONE;
  assign cmd_w = own ? (state == RD_CMD ? C2_READ_LINE : beat == '0 ? C2_WRITE_LINE : C2_NOP) : 'z;
  assign data_w = own ? line[beat*DATA_W +: DATA_W] : 'z;
  // The bus is sampled mid-cycle so the FSM never sees a half-settled tri-state value.
  always_ff @(negedge clk or posedge reset)
    if (reset) begin
      smp_cmd <= C2_NOP;
      smp_data <= '0;
    end else begin
      smp_cmd <= cmd_w;
      smp_data <= data_w;
    end
`ifdef C2_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES+1);
  logic [TW-1:0] wcnt;
  logic err;
  assign timeout = !got_resp && wcnt == TW'(TIMEOUT_CYCLES-1);
  assign resp_err = err;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wcnt <= '0;
      err <= 1'b0;
    end else begin
      wcnt <= waiting ? wcnt + 1'b1 : '0;
      err <= waiting && timeout;
    end
`else
  assign timeout = TIMEOUT_CYCLES < 0;
  assign resp_err = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = req_valid ? (req_write ? WR_BEAT : RD_CMD) : IDLE;
      RD_CMD:  state_n = RD_WAIT;
      RD_WAIT: state_n = got_resp ? (BEATS == 1 ? DONE : RD_BEAT) : timeout ? DONE : RD_WAIT;
      RD_BEAT: state_n = beat == LAST ? DONE : RD_BEAT;
      WR_BEAT: state_n = beat == LAST ? WR_WAIT : WR_BEAT;
      WR_WAIT: state_n = got_resp || timeout ? DONE : WR_WAIT;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    rbuf_n = rbuf;
    rbuf_n[beat*DATA_W +: DATA_W] = smp_data;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      own <= 1'b0;
      addr <= '0;
      line <= '0;
      beat <= '0;
      rbuf <= '0;
      resp_rdata <= '0;
    end else begin
      if (state == IDLE && req_valid) begin
        own <= 1'b1;
        addr <= req_addr;
        line <= req_wdata;
        beat <= '0;
      end
      if (state == RD_CMD || (state == WR_BEAT && beat == LAST)) own <= 1'b0;
      if (state == WR_BEAT || store) beat <= beat + 1'b1;
      if (store) rbuf <= rbuf_n;
      // Commit only on the final beat so aborted or timed-out reads leave the old line visible.
      if (store && state_n == DONE) resp_rdata <= rbuf_n;
    end
endmodule

// File: tb/tb_c2_bus_master.sv
// tb_c2_bus_master: table-driven scoreboard bench for c2_bus_master with a reactive C2 memory model.
// Build with C2_TIMEOUT_EN defined to add the no-responder timeout scenario.
module tb_c2_bus_master;
  localparam int TO = 20;
  localparam int LAT = 3;
  localparam logic [1:0] NOP = 2'd0, RDL = 2'd1, WRL = 2'd2, RSP = 2'd3;
  typedef struct {logic wr; logic [7:0] a; logic [127:0] wd;} vec_t;
  typedef struct {logic err; logic [127:0] rdata;} exp_t;
  logic clk, reset, req_valid, req_ready, req_write, resp_valid, resp_err;
  logic [7:0] req_addr, addr;
  logic [127:0] req_wdata, resp_rdata;
  wire [15:0] data_w;
  wire [1:0] cmd_w;
  logic m_own, mem_en;
  logic [1:0] m_cmd;
  logic [15:0] m_data;
  logic [7:0] mem [0:4095];
  logic [127:0] ref_line [0:255];
  logic [127:0] last_rd;
  exp_t exp_q[$];
  vec_t vecs[8];
  int checks = 0, errors = 0, ncmd = 0, nresp = 0;

  c2_bus_master #(.ADDR_W(8), .DATA_W(16), .LINE_BYTES(16), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .addr(addr), .data_w(data_w), .cmd_w(cmd_w));

  assign cmd_w = m_own ? m_cmd : 2'bz;
  assign data_w = m_own ? m_data : 16'bz;
  pulldown (cmd_w);
  pullup (data_w);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cmd_w == RDL || cmd_w == WRL) ncmd <= ncmd + 1;
    if (resp_valid) nresp <= nresp + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Memory side of the bus: captures write beats, answers reads after LAT cycles.
  initial begin
    logic [7:0] ma;
    logic [127:0] mline;
    logic ok;
    m_own = 1'b0;
    m_cmd = NOP;
    m_data = '0;
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    forever begin
      @(negedge clk);
      if (!mem_en || reset) continue;
      if (cmd_w == WRL) begin
        ma = addr;
        mline = '0;
        mline[15:0] = data_w;
        ok = 1'b1;
        for (int k = 1; k < 8; k++) begin
          @(negedge clk);
          if (reset) begin ok = 1'b0; break; end
          mline[k*16 +: 16] = data_w;
        end
        if (!ok) continue;
        repeat (LAT) @(posedge clk);
        if (reset) continue;
        for (int b = 0; b < 16; b++) mem[int'(ma)*16 + b] = mline[b*8 +: 8];
        #1 m_cmd = RSP; m_data = '0; m_own = 1'b1;
        @(posedge clk);
        #1 m_own = 1'b0; m_cmd = NOP;
      end else if (cmd_w == RDL) begin
        ma = addr;
        repeat (LAT) @(posedge clk);
        if (reset) continue;
        #1 m_own = 1'b1;
        for (int k = 0; k < 8; k++) begin
          m_cmd = k == 0 ? RSP : NOP;
          m_data = {mem[int'(ma)*16 + 2*k + 1], mem[int'(ma)*16 + 2*k]};
          @(posedge clk);
          #1;
        end
        m_own = 1'b0;
        m_cmd = NOP;
      end
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic do_req(input logic wr, input logic [7:0] a, input logic [127:0] wd);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    chk("req_ready_before_req", req_ready, 1'b1);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd;
    exp_q.push_back('{1'b0, wr ? last_rd : ref_line[a]});
    if (wr) ref_line[a] = wd;
    else last_rd = ref_line[a];
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_resp(input string nm);
    exp_t e;
    int n = 0;
    do begin @(negedge clk); n++; end while (!resp_valid && n < 300);
    chk({nm, "_resp_seen"}, resp_valid, 1'b1);
    if (!resp_valid) return;
    if (exp_q.size() == 0) begin
      chk({nm, "_unexpected_resp"}, 1'b1, 1'b0);
      return;
    end
    e = exp_q.pop_front();
    chk({nm, "_err"}, resp_err, e.err);
    chk({nm, "_rdata"}, resp_rdata, e.rdata);
    @(negedge clk);
    chk({nm, "_pulse_1cyc"}, resp_valid, 1'b0);
    chk({nm, "_ready_after"}, req_ready, 1'b1);
  endtask

  initial begin
    logic [127:0] wd, got, saved;
    int n0, nr0, n;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    mem_en = 1'b1; last_rd = '0;
    for (int i = 0; i < 256; i++) ref_line[i] = '0;
    for (int i = 0; i < 16; i++) wd[i*8 +: 8] = 8'(i);
    vecs[0] = '{1'b1, 8'h05, {$urandom, $urandom, $urandom, $urandom}};
    vecs[1] = '{1'b0, 8'h05, '0};
    vecs[2] = '{1'b1, 8'h7f, {$urandom, $urandom, $urandom, $urandom}};
    vecs[3] = '{1'b0, 8'h12, '0};
    vecs[4] = '{1'b0, 8'h7f, '0};
    vecs[5] = '{1'b1, 8'h12, 128'hffff_0000_a5a5_5a5a_0123_4567_89ab_cdef};
    vecs[6] = '{1'b0, 8'h12, '0};
    vecs[7] = '{1'b0, 8'h40, '0};
    repeat (3) @(negedge clk);
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_valid", resp_valid, 1'b0);
    chk("rst_err", resp_err, 1'b0);
    chk("rst_addr", addr, 8'h00);
    chk("rst_rdata", resp_rdata, '0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_cmd_released", cmd_w, NOP);
    chk("idle_data_released", data_w, 16'hffff);
    chk("idle_ready", req_ready, 1'b1);
    chk("idle_valid", resp_valid, 1'b0);

    n0 = ncmd; nr0 = nresp;
    do_req(1'b1, 8'h12, wd);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("wr_beat%0d_data", k), data_w, {8'(2*k+1), 8'(2*k)});
      chk($sformatf("wr_beat%0d_cmd", k), cmd_w, k == 0 ? WRL : NOP);
      if (k == 0) chk("wr_addr", addr, 8'h12);
    end
    @(negedge clk);
    chk("wr_released_data", data_w, 16'hffff);
    chk("wr_released_cmd", cmd_w, NOP);
    chk("wr_cmd_once", ncmd - n0, 1);
    wait_resp("wr1");
    for (int b = 0; b < 16; b++) got[b*8 +: 8] = mem[16'h120 + b];
    chk("wr1_mem_bytes", got, wd);
    chk("wr1_resp_once", nresp - nr0, 1);

    do_req(1'b0, 8'h12, '0);
    @(negedge clk);
    chk("rd_cmd", cmd_w, RDL);
    chk("rd_addr", addr, 8'h12);
    @(negedge clk);
    chk("rd_cmd_one_cycle", cmd_w, NOP);
    chk("rd_released_data", data_w, 16'hffff);
    wait_resp("rd1");

    for (int i = 0; i < 8; i++) begin
      do_req(vecs[i].wr, vecs[i].a, vecs[i].wd);
      wait_resp($sformatf("vec%0d", i));
    end

    n0 = ncmd;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h05;
    exp_q.push_back('{1'b0, ref_line[8'h05]});
    exp_q.push_back('{1'b0, ref_line[8'h05]});
    last_rd = ref_line[8'h05];
    wait_resp("held1");
    chk("held_one_cmd_before_done", ncmd - n0, 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_resp("held2");
    repeat (20) @(negedge clk);
    chk("held_two_cmds", ncmd - n0, 2);

    saved = ref_line[8'h12];
    nr0 = nresp;
    do_req(1'b1, 8'h12, ~wd);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_data_released", data_w, 16'hffff);
    chk("abort_cmd_released", cmd_w, NOP);
    chk("abort_ready", req_ready, 1'b1);
    exp_q.delete();
    ref_line[8'h12] = saved;
    last_rd = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    chk("abort_no_resp", nresp - nr0, 0);
    chk("abort_rdata_cleared", resp_rdata, '0);
    do_req(1'b0, 8'h12, '0);
    wait_resp("post_abort_rd");

`ifdef C2_TIMEOUT_EN
    mem_en = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h33;
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!resp_valid && n < 200);
    chk("to_latency", n, TO + 2);
    chk("to_valid", resp_valid, 1'b1);
    chk("to_err", resp_err, 1'b1);
    chk("to_rdata_kept", resp_rdata, last_rd);
    @(negedge clk);
    chk("to_valid_pulse", resp_valid, 1'b0);
    mem_en = 1'b1;
`endif
    n = exp_q.size();
    chk("scoreboard_drained", n, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
